// File: rtl/enc_serial_if.sv
// Handshake bundle for enc_serial: info word in, codeword out.
// err_mask is present only when ENC_ERR_INJ_EN is defined.
interface enc_serial_if #(
  parameter int unsigned MAX_CODEWORD_WIDTH = 32,
  parameter int unsigned MAX_INFO_WIDTH     = 26
);
  logic                          in_valid;
  logic                          in_ready;
  logic [MAX_INFO_WIDTH-1:0]     info_in;
  logic [1:0]                    work_mod;
  logic                          out_valid;
  logic                          out_ready;
  logic [MAX_CODEWORD_WIDTH-1:0] data_out;
`ifdef ENC_ERR_INJ_EN
  logic [MAX_CODEWORD_WIDTH-1:0] err_mask;
`endif

  modport master (
    output in_valid,
    output info_in,
    output work_mod,
    output out_ready,
`ifdef ENC_ERR_INJ_EN
    output err_mask,
`endif
    input  in_ready,
    input  out_valid,
    input  data_out
  );

  modport slave (
    input  in_valid,
    input  info_in,
    input  work_mod,
    input  out_ready,
`ifdef ENC_ERR_INJ_EN
    input  err_mask,
`endif
    output in_ready,
    output out_valid,
    output data_out
  );
endinterface

// File: rtl/enc_serial.sv
// Serial systematic encoder: one info bit per clock, codeword {info, overall, parity}.
// Define ENC_ERR_INJ_EN to XOR a latched err_mask onto the emitted codeword.
module enc_serial #(
  parameter int unsigned MAX_CODEWORD_WIDTH = 32,
  parameter int unsigned MAX_INFO_WIDTH     = 26
) (
  input logic         clk,
  input logic         rst,
  enc_serial_if.slave bus
);
  localparam int unsigned CW = MAX_CODEWORD_WIDTH;
  localparam int unsigned IW = MAX_INFO_WIDTH;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  // [mode][parity row r][info bit]; mode 11 has no masks.
  localparam logic [3:0][4:0][31:0] Masks = {
    {5{32'h0}},
    {32'h3FFF800, 32'h3FC07F0, 32'h3C3C78E, 32'h333366D, 32'h2AAAD5B},
    {32'h0, 32'h7F0, 32'h78E, 32'h66D, 32'h55B},
    {32'h0, 32'h0, 32'hE, 32'hD, 32'hB}
  };

  function automatic int unsigned k_of(input logic [1:0] m);
    unique case (m)
      2'd0:    return 4;
      2'd1:    return 11;
      2'd2:    return 26;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned p_of(input logic [1:0] m);
    unique case (m)
      2'd0:    return 4;
      2'd1:    return 5;
      2'd2:    return 6;
      default: return 1;
    endcase
  endfunction

  function automatic bit supported(input logic [1:0] m);
    unique case (m)
      2'd0:    return CW >= 8;
      2'd1:    return CW >= 16;
      2'd2:    return CW >= 32;
      default: return 1'b0;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic            rdy_q;
  logic [1:0]      mode_q, mode_d;
  logic [IW-1:0]   info_q, info_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [4:0]      acc_q, acc_d;
  logic [CW-1:0]   data_q, data_d;
`ifdef ENC_ERR_INJ_EN
  logic [CW-1:0]   err_q, err_d;
`endif

  logic            in_ready;
  logic [31:0]     info_ext;
  logic [31:0]     kmask;
  logic [31:0]     word;
  logic [4:0]      idx;
  logic [4:0]      col;
  logic [4:0]      acc_nx;
  logic            ovr;
  int unsigned     p;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    info_d   = info_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    data_d   = data_q;
`ifdef ENC_ERR_INJ_EN
    err_d    = err_q;
`endif
    in_ready = rdy_q && (state_q == StIdle);

    // Counter runs K-1 down to 0, so the bit being folded in is K-1-cnt.
    info_ext = 32'(info_q);
    idx      = 5'(k_of(mode_q) - 32'd1 - 32'(cnt_q));
    for (int r = 0; r < 5; r++) col[r] = Masks[mode_q][r][idx];
    acc_nx   = acc_q ^ ({5{info_ext[idx]}} & col);
    ovr      = (^info_q) ^ (^acc_nx);
    p        = p_of(mode_q);
    word     = (info_ext << p) | (32'(ovr) << (p - 32'd1)) | 32'(acc_nx);
    kmask    = (32'd1 << k_of(bus.work_mod)) - 32'd1;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && in_ready) begin
          mode_d = bus.work_mod;
          info_d = IW'(32'(bus.info_in) & kmask);
          acc_d  = '0;
`ifdef ENC_ERR_INJ_EN
          err_d  = bus.err_mask;
`endif
          if (supported(bus.work_mod)) begin
            cnt_d   = 5'(k_of(bus.work_mod) - 32'd1);
            state_d = StShift;
          end else begin
            cnt_d   = '0;
            data_d  = '0;
`ifdef ENC_ERR_INJ_EN
            data_d  = bus.err_mask;
`endif
            state_d = StDone;
          end
        end
      end
      StShift: begin
        acc_d = acc_nx;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          cnt_d   = '0;
          data_d  = word[CW-1:0];
`ifdef ENC_ERR_INJ_EN
          data_d  = word[CW-1:0] ^ err_q;
`endif
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      rdy_q   <= 1'b0;
      mode_q  <= '0;
      info_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
`ifdef ENC_ERR_INJ_EN
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      mode_q  <= mode_d;
      info_q  <= info_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
`ifdef ENC_ERR_INJ_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == StDone);
  assign bus.data_out  = data_q;

endmodule
